insfetch_q: RTL and testbench

INSFETCH_Q -- requirements
Module: insfetch_q

---
 rtl/insfetch_q_if.sv | 39 +++
 rtl/insfetch_q.sv | 191 +++++++++++++++++++
 tb/tb_insfetch_q.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/insfetch_q_if.sv
// Fetch-queue bundle: inscache request/response, decoder head port, redirect
// and branch-resolution feedback. The fetch block drives the master side.
interface insfetch_q_if #(
  parameter int unsigned FQ_DEPTH  = 4,
  parameter int unsigned PHT_IDX_W = 8
);
  localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;

  logic [31:0]          out_PC;
  logic                 ask_for;
  logic                 give_you;
  logic [31:0]          g_ins;
  logic                 dc_valid;
  logic                 dc_ready;
  logic [31:0]          dc_addr;
  logic [31:0]          dc_ins;
  logic                 dc_pred_jmp;
  logic [31:0]          dc_alt_pc;
  logic [CNT_W-1:0]     fq_count;
  logic                 rob_clear;
  logic [31:0]          rob_new_pc;
  logic                 cancel_stuck;
  logic [31:0]          jalr_new_pc;
  logic                 is_res;
  logic [PHT_IDX_W-1:0] res_pc_part;
  logic                 res_jmp;

  modport master (
    output out_PC, ask_for, dc_valid, dc_addr, dc_ins, dc_pred_jmp, dc_alt_pc, fq_count,
    input  give_you, g_ins, dc_ready, rob_clear, rob_new_pc, cancel_stuck, jalr_new_pc,
           is_res, res_pc_part, res_jmp
  );

  modport slave (
    input  out_PC, ask_for, dc_valid, dc_addr, dc_ins, dc_pred_jmp, dc_alt_pc, fq_count,
    output give_you, g_ins, dc_ready, rob_clear, rob_new_pc, cancel_stuck, jalr_new_pc,
           is_res, res_pc_part, res_jmp
  );
endinterface

// File: rtl/insfetch_q.sv
// Instruction fetch with predecode, bimodal branch predictor and a small
// fetch queue feeding the decoder; stalls on indirect jumps until resolved.
module insfetch_q #(
  parameter int unsigned FQ_DEPTH  = 4,
  parameter int unsigned PHT_IDX_W = 8,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned RVC_EN    = 1
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          rdy_in,
  insfetch_q_if.master  fq
);
  localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned PHT_N = 1 << PHT_IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FQ_DEPTH);

  typedef enum logic {ST_FETCH, ST_STUCK} fetch_state_e;
  typedef enum logic [1:0] {CL_PLAIN, CL_JAL, CL_JALR, CL_BR} ins_class_e;

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      q_addr_q [FQ_DEPTH];
  logic [31:0]      q_ins_q  [FQ_DEPTH];
  logic             q_pred_q [FQ_DEPTH];
  logic [31:0]      q_alt_q  [FQ_DEPTH];
  logic [CTR_W-1:0] pht_q    [PHT_N];

  logic [31:0]          ins;
  logic                 is_rvc;
  logic [31:0]          len;
  logic [31:0]          imm;
  ins_class_e           cls;
  logic                 push;
  logic                 pop;
  logic [PHT_IDX_W-1:0] pht_idx;
  logic                 pred_taken;
  logic [31:0]          seq_pc;
  logic [31:0]          tgt_pc;
  logic                 ent_pred;
  logic [31:0]          ent_alt;
  logic [CTR_W-1:0]     pht_upd_d;

  assign ins = fq.g_ins;

  // Predecode: classify the incoming word and extract its PC-relative offset.
  always_comb begin
    is_rvc = (RVC_EN != 0) && (ins[1:0] != 2'b11);
    len    = is_rvc ? 32'd2 : 32'd4;
    cls    = CL_PLAIN;
    imm    = '0;
    if (is_rvc) begin
      if (ins[1:0] == 2'b01 && (ins[15:13] == 3'b101 || ins[15:13] == 3'b001)) begin
        cls = CL_JAL;
        imm = {{20{ins[12]}}, ins[12], ins[8], ins[10:9], ins[6], ins[7], ins[2],
               ins[11], ins[5:3], 1'b0};
      end else if (ins[1:0] == 2'b01 && ins[15:14] == 2'b11) begin
        cls = CL_BR;
        imm = {{23{ins[12]}}, ins[12], ins[6:5], ins[2], ins[11:10], ins[4:3], 1'b0};
      end else if (ins[1:0] == 2'b10 && ins[15:13] == 3'b100 && ins[6:2] == 5'd0) begin
        cls = CL_JALR;
      end
    end else begin
      unique case (ins[6:0])
        7'b1101111: begin
          cls = CL_JAL;
          imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        end
        7'b1100111: cls = CL_JALR;
        7'b1100011: begin
          cls = CL_BR;
          imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        end
        default: cls = CL_PLAIN;
      endcase
    end
  end

  assign fq.out_PC      = pc_q;
  assign fq.ask_for     = rdy_in && (state_q == ST_FETCH) && (count_q < CNT_FULL);
  assign fq.dc_valid    = (count_q != '0);
  assign fq.dc_addr     = q_addr_q[rd_ptr_q];
  assign fq.dc_ins      = q_ins_q[rd_ptr_q];
  assign fq.dc_pred_jmp = q_pred_q[rd_ptr_q];
  assign fq.dc_alt_pc   = q_alt_q[rd_ptr_q];
  assign fq.fq_count    = count_q;

  assign push       = fq.ask_for && fq.give_you && !fq.rob_clear;
  assign pop        = rdy_in && fq.dc_valid && fq.dc_ready && !fq.rob_clear;
  assign pht_idx    = pc_q[PHT_IDX_W:1];
  assign pred_taken = pht_q[pht_idx][CTR_W-1];
  assign seq_pc     = pc_q + len;
  assign tgt_pc     = pc_q + imm;

  always_comb begin
    pc_d     = pc_q;
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ent_pred = 1'b0;
    ent_alt  = seq_pc;
    if (fq.rob_clear) begin
      pc_d     = fq.rob_new_pc;
      state_d  = ST_FETCH;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (state_q == ST_STUCK && fq.cancel_stuck) begin
        pc_d    = fq.jalr_new_pc;
        state_d = ST_FETCH;
      end
      if (push) begin
        unique case (cls)
          CL_JALR: state_d = ST_STUCK;
          CL_JAL: begin
            pc_d     = tgt_pc;
            ent_pred = 1'b1;
          end
          CL_BR: begin
            ent_pred = pred_taken;
            pc_d     = pred_taken ? tgt_pc : seq_pc;
            ent_alt  = pred_taken ? seq_pc : tgt_pc;
          end
          default: pc_d = seq_pc;
        endcase
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Saturating counter update; the lookup above uses the pre-update value.
  always_comb begin
    pht_upd_d = pht_q[fq.res_pc_part];
    if (fq.res_jmp) begin
      if (pht_upd_d != CTR_MAX) pht_upd_d = pht_upd_d + CTR_W'(1);
    end else begin
      if (pht_upd_d != '0) pht_upd_d = pht_upd_d - CTR_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
        q_addr_q[i] <= '0;
        q_ins_q[i]  <= '0;
        q_pred_q[i] <= 1'b0;
        q_alt_q[i]  <= '0;
      end
      for (int unsigned j = 0; j < PHT_N; j++) begin
        pht_q[j] <= CTR_INIT;
      end
    end else if (rdy_in) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        q_addr_q[wr_ptr_q] <= pc_q;
        q_ins_q[wr_ptr_q]  <= ins;
        q_pred_q[wr_ptr_q] <= ent_pred;
        q_alt_q[wr_ptr_q]  <= ent_alt;
      end
      if (fq.is_res) begin
        pht_q[fq.res_pc_part] <= pht_upd_d;
      end
    end
  end
endmodule

// File: tb/tb_insfetch_q.sv
// Directed bench for insfetch_q: queue fill/drain, prediction, stall on
// indirect jumps, redirect, predictor saturation and asynchronous reset.
module tb_insfetch_q;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] BEQ16 = 32'h0000_0863;  // beq x0,x0,+16
  localparam logic [31:0] CJR   = 32'h0000_8082;  // c.jr x1
  localparam logic [31:0] CNOP  = 32'h0000_0001;  // c.nop
  localparam logic [31:0] JAL8  = 32'h0080_006F;  // jal x0,+8
  localparam logic [31:0] CJ4   = 32'h0000_A011;  // c.j +4

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  int unsigned errors = 0;
  int unsigned checks = 0;

  insfetch_q_if #(.FQ_DEPTH(4), .PHT_IDX_W(8)) bus ();

  insfetch_q #(.FQ_DEPTH(4), .PHT_IDX_W(8), .CTR_W(2), .RVC_EN(1)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .rdy_in  (rdy),
    .fq      (bus.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input logic [31:0] pc);
    bus.give_you  = 1'b0;
    bus.dc_ready  = 1'b0;
    bus.rob_clear = 1'b1;
    bus.rob_new_pc = pc;
    step();
    bus.rob_clear = 1'b0;
  endtask

  task automatic push1(input logic [31:0] w);
    bus.g_ins    = w;
    bus.give_you = 1'b1;
    step();
    bus.give_you = 1'b0;
  endtask

  task automatic res(input logic [7:0] idx, input logic jmp, input int n);
    for (int k = 0; k < n; k++) begin
      bus.is_res = 1'b1; bus.res_pc_part = idx; bus.res_jmp = jmp;
      step();
    end
    bus.is_res = 1'b0;
  endtask

  task automatic test_reset();
    bus.give_you = 0; bus.g_ins = '0; bus.dc_ready = 0; bus.rob_clear = 0;
    bus.rob_new_pc = '0; bus.cancel_stuck = 0; bus.jalr_new_pc = '0;
    bus.is_res = 0; bus.res_pc_part = '0; bus.res_jmp = 0;
    #1;
    checks++; if (bus.fq_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.fq_count); end
    checks++; if (bus.dc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.dc_valid); end
    checks++; if (bus.out_PC !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", bus.out_PC); end
    checks++; if (bus.ask_for !== 1'b1) begin errors++; $display("FAIL reset_ask got=%b exp=1", bus.ask_for); end
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    bus.g_ins = NOP; bus.give_you = 1; bus.dc_ready = 0;
    repeat (4) step();
    checks++; if (bus.fq_count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", bus.fq_count); end
    checks++; if (bus.ask_for !== 1'b0) begin errors++; $display("FAIL fill_ask got=%b exp=0", bus.ask_for); end
    checks++; if (bus.out_PC !== 32'h10) begin errors++; $display("FAIL fill_pc got=%h exp=10", bus.out_PC); end
    checks++; if (bus.dc_addr !== 32'h0 || bus.dc_ins !== NOP) begin errors++; $display("FAIL fill_head got=%h/%h exp=0/%h", bus.dc_addr, bus.dc_ins, NOP); end
    checks++; if (bus.dc_pred_jmp !== 1'b0 || bus.dc_alt_pc !== 32'h4) begin errors++; $display("FAIL fill_head_pred got=%b/%h exp=0/4", bus.dc_pred_jmp, bus.dc_alt_pc); end
    step();
    checks++; if (bus.fq_count !== 3'd4 || bus.out_PC !== 32'h10) begin errors++; $display("FAIL full_hold got=%0d/%h exp=4/10", bus.fq_count, bus.out_PC); end
  endtask

  task automatic test_full_pop();
    bus.dc_ready = 1;
    step();
    checks++; if (bus.fq_count !== 3'd3 || bus.out_PC !== 32'h10) begin errors++; $display("FAIL full_pop got=%0d/%h exp=3/10", bus.fq_count, bus.out_PC); end
    checks++; if (bus.dc_addr !== 32'h4) begin errors++; $display("FAIL full_pop_head got=%h exp=4", bus.dc_addr); end
  endtask

  task automatic test_back_to_back();
    step();
    checks++; if (bus.fq_count !== 3'd3 || bus.out_PC !== 32'h14) begin errors++; $display("FAIL pushpop got=%0d/%h exp=3/14", bus.fq_count, bus.out_PC); end
    checks++; if (bus.dc_addr !== 32'h8) begin errors++; $display("FAIL pushpop_head got=%h exp=8", bus.dc_addr); end
    bus.give_you = 0;
    step(); step();
    checks++; if (bus.fq_count !== 3'd1 || bus.dc_addr !== 32'h10) begin errors++; $display("FAIL wrap_head got=%0d/%h exp=1/10", bus.fq_count, bus.dc_addr); end
    step();
    checks++; if (bus.dc_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b exp=0", bus.dc_valid); end
  endtask

  task automatic test_freeze();
    rdy = 0; bus.give_you = 1; bus.g_ins = NOP;
    step(); step();
    checks++; if (bus.ask_for !== 1'b0 || bus.fq_count !== 3'd0 || bus.out_PC !== 32'h14) begin
      errors++; $display("FAIL freeze got=%b/%0d/%h exp=0/0/14", bus.ask_for, bus.fq_count, bus.out_PC); end
    bus.give_you = 0; rdy = 1;
  endtask

  task automatic test_branch();
    flush(32'h20);
    push1(BEQ16);
    checks++; if (bus.dc_pred_jmp !== 1'b1 || bus.out_PC !== 32'h30 || bus.dc_alt_pc !== 32'h24) begin
      errors++; $display("FAIL br_taken got=%b/%h/%h exp=1/30/24", bus.dc_pred_jmp, bus.out_PC, bus.dc_alt_pc); end
    checks++; if (bus.dc_addr !== 32'h20 || bus.dc_ins !== BEQ16) begin errors++; $display("FAIL br_entry got=%h/%h exp=20/%h", bus.dc_addr, bus.dc_ins, BEQ16); end
    res(8'd16, 1'b0, 1);
    flush(32'h20);
    push1(BEQ16);
    checks++; if (bus.dc_pred_jmp !== 1'b0 || bus.out_PC !== 32'h24 || bus.dc_alt_pc !== 32'h30) begin
      errors++; $display("FAIL br_not_taken got=%b/%h/%h exp=0/24/30", bus.dc_pred_jmp, bus.out_PC, bus.dc_alt_pc); end
  endtask

  task automatic test_stuck();
    flush(32'h40);
    push1(CJR);
    checks++; if (bus.ask_for !== 1'b0 || bus.out_PC !== 32'h40) begin errors++; $display("FAIL stuck got=%b/%h exp=0/40", bus.ask_for, bus.out_PC); end
    checks++; if (bus.dc_pred_jmp !== 1'b0 || bus.dc_alt_pc !== 32'h42) begin errors++; $display("FAIL stuck_entry got=%b/%h exp=0/42", bus.dc_pred_jmp, bus.dc_alt_pc); end
    bus.give_you = 1; bus.g_ins = NOP; bus.dc_ready = 1;
    step();
    checks++; if (bus.fq_count !== 3'd0 || bus.out_PC !== 32'h40) begin errors++; $display("FAIL stuck_drain got=%0d/%h exp=0/40", bus.fq_count, bus.out_PC); end
    bus.give_you = 0; bus.dc_ready = 0;
    bus.cancel_stuck = 1; bus.jalr_new_pc = 32'h100;
    step();
    bus.cancel_stuck = 0;
    checks++; if (bus.out_PC !== 32'h100 || bus.ask_for !== 1'b1) begin errors++; $display("FAIL unstuck got=%h/%b exp=100/1", bus.out_PC, bus.ask_for); end
  endtask

  task automatic test_jumps();
    push1(CNOP);
    checks++; if (bus.out_PC !== 32'h102 || bus.dc_alt_pc !== 32'h102) begin errors++; $display("FAIL cnop got=%h/%h exp=102/102", bus.out_PC, bus.dc_alt_pc); end
    bus.dc_ready = 1;
    push1(JAL8);
    bus.dc_ready = 0;
    checks++; if (bus.out_PC !== 32'h10A || bus.dc_pred_jmp !== 1'b1 || bus.dc_alt_pc !== 32'h106) begin
      errors++; $display("FAIL jal got=%h/%b/%h exp=10a/1/106", bus.out_PC, bus.dc_pred_jmp, bus.dc_alt_pc); end
    bus.dc_ready = 1;
    push1(CJ4);
    bus.dc_ready = 0;
    checks++; if (bus.out_PC !== 32'h10E || bus.dc_pred_jmp !== 1'b1 || bus.dc_alt_pc !== 32'h10C) begin
      errors++; $display("FAIL cj got=%h/%b/%h exp=10e/1/10c", bus.out_PC, bus.dc_pred_jmp, bus.dc_alt_pc); end
  endtask

  task automatic test_clear();
    flush(32'h0);
    bus.g_ins = NOP; bus.give_you = 1;
    repeat (3) step();
    checks++; if (bus.fq_count !== 3'd3) begin errors++; $display("FAIL clear_pre got=%0d exp=3", bus.fq_count); end
    bus.rob_clear = 1; bus.rob_new_pc = 32'h200; bus.dc_ready = 1;
    step();
    bus.rob_clear = 0; bus.give_you = 0; bus.dc_ready = 0;
    checks++; if (bus.fq_count !== 3'd0 || bus.out_PC !== 32'h200 || bus.dc_valid !== 1'b0) begin
      errors++; $display("FAIL clear got=%0d/%h/%b exp=0/200/0", bus.fq_count, bus.out_PC, bus.dc_valid); end
  endtask

  task automatic test_pht();
    res(8'd5, 1'b0, 3);
    flush(32'h0A); push1(BEQ16);
    checks++; if (bus.dc_pred_jmp !== 1'b0 || bus.out_PC !== 32'h0E) begin errors++; $display("FAIL pht_sat_low got=%b/%h exp=0/e", bus.dc_pred_jmp, bus.out_PC); end
    res(8'd5, 1'b1, 4);
    flush(32'h0A); push1(BEQ16);
    checks++; if (bus.dc_pred_jmp !== 1'b1 || bus.out_PC !== 32'h1A) begin errors++; $display("FAIL pht_inc got=%b/%h exp=1/1a", bus.dc_pred_jmp, bus.out_PC); end
    res(8'd5, 1'b0, 1);
    flush(32'h0A); push1(BEQ16);
    checks++; if (bus.dc_pred_jmp !== 1'b1) begin errors++; $display("FAIL pht_sat_high got=%b exp=1", bus.dc_pred_jmp); end
    rdy = 0; res(8'd5, 1'b0, 2); rdy = 1;
    flush(32'h0A);
    bus.is_res = 1; bus.res_pc_part = 8'd5; bus.res_jmp = 0;
    push1(BEQ16);
    bus.is_res = 0;
    checks++; if (bus.dc_pred_jmp !== 1'b1) begin errors++; $display("FAIL pht_bypass got=%b exp=1", bus.dc_pred_jmp); end
    flush(32'h0A); push1(BEQ16);
    checks++; if (bus.dc_pred_jmp !== 1'b0 || bus.dc_alt_pc !== 32'h1A) begin errors++; $display("FAIL pht_after got=%b/%h exp=0/1a", bus.dc_pred_jmp, bus.dc_alt_pc); end
  endtask

  task automatic test_reset_mid();
    flush(32'h40);
    push1(CJR);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.dc_valid !== 1'b0 || bus.out_PC !== 32'h0 || bus.ask_for !== 1'b1) begin
      errors++; $display("FAIL rst_mid got=%b/%h/%b exp=0/0/1", bus.dc_valid, bus.out_PC, bus.ask_for); end
    bus.g_ins = NOP; bus.give_you = 1;
    #2 rst_n = 1'b1;
    #1;
    checks++; if (bus.fq_count !== 3'd0) begin errors++; $display("FAIL rst_release got=%0d exp=0", bus.fq_count); end
    step();
    bus.give_you = 0;
    checks++; if (bus.fq_count !== 3'd1 || bus.dc_addr !== 32'h0 || bus.out_PC !== 32'h4) begin
      errors++; $display("FAIL rst_first_push got=%0d/%h/%h exp=1/0/4", bus.fq_count, bus.dc_addr, bus.out_PC); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pop();
    test_back_to_back();
    test_freeze();
    test_branch();
    test_stuck();
    test_jumps();
    test_clear();
    test_pht();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
